// File: rtl/barrel_shift_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : barrel_shift_pipe
//  Description : Pipelined barrel shifter with valid/ready handshake.
//                One register stage per shift-amount bit; stage k shifts by
//                2^k when bit k of the beat's shift amount is set.
//                Ops: 0 LSR, 1 ASR, 2 LSL, 3 ROR, 4 ROL, 5..7 illegal
//                (data passes through unchanged and out_err is raised).
//                Left ops run as reverse -> right op -> reverse.
//  Ports       : clk, rst_n (sync, active-low)
//                in_valid/in_ready, in_data[N], in_shift[log2 N],
//                in_op[3], in_tag[TAG_W]           -- input beat
//                out_valid/out_ready, out_data[N], out_tag[TAG_W],
//                out_err                           -- result beat
//  Revision    : 1.0 - initial release
// ============================================================================
module barrel_shift_pipe #(
    parameter int N     = 8,
    parameter int TAG_W = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [N-1:0]         in_data,
    input  logic [$clog2(N)-1:0] in_shift,
    input  logic [2:0]           in_op,
    input  logic [TAG_W-1:0]     in_tag,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [N-1:0]         out_data,
    output logic [TAG_W-1:0]     out_tag,
    output logic                 out_err
);

    localparam int         c_S      = $clog2(N);
    localparam logic [2:0] c_OP_ASR = 3'd1;
    localparam logic [2:0] c_OP_LSL = 3'd2;
    localparam logic [2:0] c_OP_ROR = 3'd3;
    localparam logic [2:0] c_OP_ROL = 3'd4;

    function automatic logic [N-1:0] bit_reverse(input logic [N-1:0] d);
        logic [N-1:0] r;
        for (int i = 0; i < N; i++) begin
            r[i] = d[N-1-i];
        end
        return r;
    endfunction

    function automatic logic is_left(input logic [2:0] op);
        return (op == c_OP_LSL) || (op == c_OP_ROL);
    endfunction

    // Right-direction shift by a fixed amount. LSL arrives here already
    // bit-reversed, so it shares the logical-right path with LSR.
    function automatic logic [N-1:0] shift_right(input logic [N-1:0] d,
                                                 input logic [2:0]   op,
                                                 input int           amt);
        logic [N-1:0] r;
        case (op)
            c_OP_ASR:           r = $unsigned($signed(d) >>> amt);
            c_OP_ROR, c_OP_ROL: r = (d >> amt) | (d << (N - amt));
            default:            r = d >> amt;
        endcase
        return r;
    endfunction

    // Stage registers
    logic             r_valid [c_S];
    logic [N-1:0]     r_data  [c_S];
    logic [c_S-1:0]   r_shift [c_S];
    logic [2:0]       r_op    [c_S];
    logic [TAG_W-1:0] r_tag   [c_S];
    logic             r_err   [c_S];

    // Beat entering each stage, and the value it will register
    logic             w_src_valid [c_S];
    logic [N-1:0]     w_src_data  [c_S];
    logic [c_S-1:0]   w_src_shift [c_S];
    logic [2:0]       w_src_op    [c_S];
    logic [TAG_W-1:0] w_src_tag   [c_S];
    logic             w_src_err   [c_S];

    logic             w_nxt_valid [c_S];
    logic [N-1:0]     w_nxt_data  [c_S];
    logic [c_S-1:0]   w_nxt_shift [c_S];
    logic [2:0]       w_nxt_op    [c_S];
    logic [TAG_W-1:0] w_nxt_tag   [c_S];
    logic             w_nxt_err   [c_S];

    logic             w_adv;

    always_comb begin
        // Stage 0 is fed from the input port; left ops are reversed here so
        // every stage only ever shifts right.
        w_src_valid[0] = in_valid;
        w_src_data[0]  = is_left(in_op) ? bit_reverse(in_data) : in_data;
        w_src_shift[0] = in_shift;
        w_src_op[0]    = in_op;
        w_src_tag[0]   = in_tag;
        w_src_err[0]   = (in_op > c_OP_ROL);
        for (int k = 1; k < c_S; k++) begin
            w_src_valid[k] = r_valid[k-1];
            w_src_data[k]  = r_data[k-1];
            w_src_shift[k] = r_shift[k-1];
            w_src_op[k]    = r_op[k-1];
            w_src_tag[k]   = r_tag[k-1];
            w_src_err[k]   = r_err[k-1];
        end

        for (int k = 0; k < c_S; k++) begin
            w_nxt_valid[k] = w_src_valid[k];
            w_nxt_shift[k] = w_src_shift[k];
            w_nxt_op[k]    = w_src_op[k];
            w_nxt_tag[k]   = w_src_tag[k];
            w_nxt_err[k]   = w_src_err[k];
            if (w_src_shift[k][k] && !w_src_err[k]) begin
                w_nxt_data[k] = shift_right(w_src_data[k], w_src_op[k], 1 << k);
            end else begin
                w_nxt_data[k] = w_src_data[k];
            end
        end

        // Undo the input reversal before the final register so out_data is
        // a plain register output.
        if (is_left(w_src_op[c_S-1])) begin
            w_nxt_data[c_S-1] = bit_reverse(w_nxt_data[c_S-1]);
        end
    end

    // The whole pipe moves as one unit: it advances unless a finished
    // result is stuck at the output.
    assign w_adv    = !r_valid[c_S-1] || out_ready;
    assign in_ready = w_adv;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int k = 0; k < c_S; k++) begin
                r_valid[k] <= 1'b0;
                r_data[k]  <= '0;
                r_shift[k] <= '0;
                r_op[k]    <= '0;
                r_tag[k]   <= '0;
                r_err[k]   <= 1'b0;
            end
        end else if (w_adv) begin
            for (int k = 0; k < c_S; k++) begin
                r_valid[k] <= w_nxt_valid[k];
                r_data[k]  <= w_nxt_data[k];
                r_shift[k] <= w_nxt_shift[k];
                r_op[k]    <= w_nxt_op[k];
                r_tag[k]   <= w_nxt_tag[k];
                r_err[k]   <= w_nxt_err[k];
            end
        end
    end

    assign out_valid = r_valid[c_S-1];
    assign out_data  = r_data[c_S-1];
    assign out_tag   = r_tag[c_S-1];
    assign out_err   = r_err[c_S-1];

endmodule
`default_nettype wire

// File: tb/tb_barrel_shift_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : tb_barrel_shift_pipe
//  Description : Self-checking bench for barrel_shift_pipe. Four instances
//                (N = 2, 8, 16, 64) each get a queue-based reference model
//                that predicts out_valid, in_ready and every result from
//                the arithmetic definition of each op. The N = 8 instance
//                also runs hand-computed directed cases before going random.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_barrel_shift_pipe;

    localparam int TAG_W       = 4;
    localparam int NCFG        = 4;
    localparam int RAND_CYCLES = 3000;

    typedef struct {
        logic [63:0]      data;
        logic [TAG_W-1:0] tag;
        logic             err;
        int               age;   // clock edges with the pipe advancing since accept
    } beat_t;

    logic clk = 1'b0;
    int   checks   = 0;
    int   failures = 0;
    int   n_done   = 0;

    always #5 clk = ~clk;

    function automatic logic [63:0] width_mask(input int w);
        if (w >= 64) return {64{1'b1}};
        return (64'd1 << w) - 64'd1;
    endfunction

    // Mathematical definition of each op on a w-bit value
    function automatic logic [63:0] ref_shift(input logic [63:0] d_in, input int sh,
                                              input int op, input int w);
        logic [63:0] m;
        logic [63:0] d;
        m = width_mask(w);
        d = d_in & m;
        case (op)
            0:       return d >> sh;
            1:       return (d >> sh) | (d[w-1] ? (m & ~(m >> sh)) : 64'd0);
            2:       return (d << sh) & m;
            3:       return ((d >> sh) | (d << (w - sh))) & m;
            4:       return ((d << sh) | (d >> (w - sh))) & m;
            default: return d;
        endcase
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    for (genvar gi = 0; gi < NCFG; gi++) begin : g_cfg
        localparam int W  = (gi == 0) ? 2 : (gi == 1) ? 8 : (gi == 2) ? 16 : 64;
        localparam int SW = $clog2(W);

        logic             rst_n;
        logic             in_valid, in_ready, out_valid, out_ready, out_err;
        logic [W-1:0]     in_data, out_data;
        logic [SW-1:0]    in_shift;
        logic [2:0]       in_op;
        logic [TAG_W-1:0] in_tag, out_tag;
        beat_t            q[$];
        int               tag_ctr = 0;

        barrel_shift_pipe #(.N(W), .TAG_W(TAG_W)) u_dut (
            .clk       (clk),
            .rst_n     (rst_n),
            .in_valid  (in_valid),
            .in_ready  (in_ready),
            .in_data   (in_data),
            .in_shift  (in_shift),
            .in_op     (in_op),
            .in_tag    (in_tag),
            .out_valid (out_valid),
            .out_ready (out_ready),
            .out_data  (out_data),
            .out_tag   (out_tag),
            .out_err   (out_err)
        );

        // Compare process: inputs change just after posedge, so the negedge
        // sees the values that the coming posedge will act on.
        always @(negedge clk) begin : p_model
            logic  exp_valid;
            logic  adv;
            beat_t b;
            if (!rst_n) begin
                q.delete();
            end else begin
                exp_valid = (q.size() > 0) && (q[0].age == SW);
                check($sformatf("w%0d out_valid", W), 64'(out_valid), 64'(exp_valid));
                check($sformatf("w%0d in_ready", W), 64'(in_ready), 64'(!exp_valid || out_ready));
                if (exp_valid && out_valid) begin
                    check($sformatf("w%0d out_data", W), 64'(out_data), q[0].data);
                    check($sformatf("w%0d out_tag", W), 64'(out_tag), 64'(q[0].tag));
                    check($sformatf("w%0d out_err", W), 64'(out_err), 64'(q[0].err));
                end
                adv = !exp_valid || out_ready;
                if (exp_valid && out_ready) void'(q.pop_front());
                if (adv) begin
                    for (int i = 0; i < q.size(); i++) q[i].age = q[i].age + 1;
                end
                if (in_valid && adv) begin
                    b.data = ref_shift(64'(in_data), int'(in_shift), int'(in_op), W);
                    b.tag  = in_tag;
                    b.err  = (in_op > 3'd4);
                    b.age  = 1;
                    q.push_back(b);
                end
            end
        end

        task automatic reset_dut();
            rst_n = 1'b0; in_valid = 1'b0; in_data = '0; in_shift = '0;
            in_op = '0; in_tag = '0; out_ready = 1'b0;
            repeat (3) @(posedge clk);
            #1 rst_n = 1'b1;
        endtask

        task automatic run_random(input int cycles);
            for (int c = 0; c < cycles; c++) begin
                @(posedge clk); #1;
                in_valid  = ($urandom_range(0, 3) != 0);
                in_data   = W'({$urandom(), $urandom()});
                in_shift  = SW'($urandom_range(0, W - 1));
                in_op     = 3'($urandom_range(0, 7));
                in_tag    = TAG_W'(tag_ctr);
                out_ready = ($urandom_range(0, 3) != 0);
                tag_ctr++;
            end
            @(posedge clk); #1;
            in_valid  = 1'b0;
            out_ready = 1'b1;
            repeat (SW + 2) @(posedge clk);
            #1;
            check($sformatf("w%0d drained", W), 64'(q.size()), 64'd0);
        endtask

        if (W == 8) begin : g_dir
            task automatic send_one(input logic [7:0] d, input logic [2:0] sh,
                                    input logic [2:0] op, input logic [3:0] tag,
                                    output int lat, output logic [7:0] rd, output logic re);
                @(posedge clk); #1;
                in_valid = 1'b1; in_data = d; in_shift = sh; in_op = op;
                in_tag = tag; out_ready = 1'b1;
                @(posedge clk); #1;
                in_valid = 1'b0;
                lat = 1;
                while (!out_valid && lat < 10) begin
                    @(posedge clk); #1;
                    lat++;
                end
                rd = out_data;
                re = out_err;
            endtask

            task automatic run_directed();
                int         lat, n, first, last, seen;
                logic [7:0] rd, hold_data;
                logic [3:0] hold_tag;
                logic       re;
                logic [7:0] lit [5];
                int         acc[$];

                // Reset state and first cycle after release
                check("reset out_valid", 64'(out_valid), 64'd0);
                check("reset out_data", 64'(out_data), 64'd0);
                check("reset out_tag", 64'(out_tag), 64'd0);
                check("reset out_err", 64'(out_err), 64'd0);
                check("in_ready after reset", 64'(in_ready), 64'd1);

                // Pin the model at other widths
                check("model w64 asr", ref_shift(64'h8000_0000_0000_0001, 1, 1, 64), 64'hC000_0000_0000_0000);
                check("model w64 rol", ref_shift(64'h8000_0000_0000_0001, 1, 4, 64), 64'h0000_0000_0000_0003);
                check("model w2 ror", ref_shift(64'h1, 1, 3, 2), 64'h2);

                // 0x96 shifted by 3 through each legal op
                lit = '{8'h12, 8'hF2, 8'hB0, 8'hD2, 8'hB4};
                for (int op = 0; op < 5; op++) begin
                    check($sformatf("model 0x96 op%0d", op), ref_shift(64'h96, 3, op, 8), 64'(lit[op]));
                    send_one(8'h96, 3'd3, 3'(op), 4'(op), lat, rd, re);
                    check($sformatf("0x96 op%0d data", op), 64'(rd), 64'(lit[op]));
                    check($sformatf("0x96 op%0d latency", op), 64'(lat), 64'd3);
                    check($sformatf("0x96 op%0d err", op), 64'(re), 64'd0);
                end

                // Illegal op, then a legal one
                send_one(8'h5A, 3'd2, 3'd6, 4'hA, lat, rd, re);
                check("illegal data", 64'(rd), 64'h5A);
                check("illegal err", 64'(re), 64'd1);
                send_one(8'h5A, 3'd2, 3'd0, 4'hB, lat, rd, re);
                check("after illegal data", 64'(rd), 64'h16);
                check("after illegal err", 64'(re), 64'd0);

                // Eight back-to-back beats at full rate
                @(posedge clk); #1;
                out_ready = 1'b1;
                n = 0; first = -1; last = -1;
                for (int c = 0; c < 20; c++) begin
                    if (out_valid) begin
                        check($sformatf("b2b tag #%0d", n), 64'(out_tag), 64'(n));
                        if (n == 0) first = c;
                        last = c;
                        n++;
                    end
                    if (c < 8) begin
                        in_valid = 1'b1;
                        in_data  = 8'($urandom());
                        in_shift = 3'($urandom_range(0, 7));
                        in_op    = 3'($urandom_range(0, 4));
                        in_tag   = 4'(c);
                    end else begin
                        in_valid = 1'b0;
                    end
                    @(posedge clk); #1;
                end
                check("b2b count", 64'(n), 64'd8);
                check("b2b consecutive", 64'(last - first), 64'd7);

                // Backpressure: fill, stall, release
                out_ready = 1'b0;
                @(posedge clk); #1;
                for (int c = 0; c < 6; c++) begin
                    if (in_ready) acc.push_back(8 + c);
                    in_valid = 1'b1;
                    in_data  = 8'($urandom());
                    in_shift = 3'($urandom_range(0, 7));
                    in_op    = 3'($urandom_range(0, 4));
                    in_tag   = 4'(8 + c);
                    @(posedge clk); #1;
                end
                in_valid = 1'b0;
                check("stall accepted", 64'(acc.size()), 64'd3);
                hold_data = out_data;
                hold_tag  = out_tag;
                check("stall head tag", 64'(hold_tag), 64'd8);
                for (int c = 0; c < 5; c++) begin
                    check("stall in_ready", 64'(in_ready), 64'd0);
                    check("stall out_data", 64'(out_data), 64'(hold_data));
                    check("stall out_tag", 64'(out_tag), 64'(hold_tag));
                    @(posedge clk); #1;
                end
                out_ready = 1'b1;
                n = 0;
                for (int c = 0; c < 8; c++) begin
                    if (out_valid) begin
                        if (n < acc.size()) check("drain tag", 64'(out_tag), 64'(acc[n]));
                        n++;
                    end
                    @(posedge clk); #1;
                end
                check("drain count", 64'(n), 64'd3);

                // Reset with three beats in flight
                out_ready = 1'b0;
                for (int c = 0; c < 3; c++) begin
                    in_valid = 1'b1;
                    in_data  = 8'($urandom());
                    in_shift = 3'($urandom_range(0, 7));
                    in_op    = 3'($urandom_range(0, 4));
                    in_tag   = 4'(12 + c);
                    @(posedge clk); #1;
                end
                in_valid = 1'b0;
                rst_n    = 1'b0;
                @(posedge clk); #1;
                check("flush out_valid", 64'(out_valid), 64'd0);
                check("flush out_data", 64'(out_data), 64'd0);
                check("flush out_tag", 64'(out_tag), 64'd0);
                check("flush out_err", 64'(out_err), 64'd0);
                rst_n     = 1'b1;
                out_ready = 1'b1;
                check("flush in_ready", 64'(in_ready), 64'd1);
                seen = 0;
                for (int c = 0; c < 10; c++) begin
                    if (out_valid) seen++;
                    @(posedge clk); #1;
                end
                check("flush no late results", 64'(seen), 64'd0);
            endtask

            initial begin
                reset_dut();
                run_directed();
                run_random(RAND_CYCLES);
                n_done++;
            end
        end else begin : g_rnd
            initial begin
                reset_dut();
                run_random(RAND_CYCLES);
                n_done++;
            end
        end
    end

    initial begin : p_finish
        int waited;
        waited = 0;
        while (n_done < NCFG && waited < 20000) begin
            @(posedge clk);
            waited++;
        end
        if (n_done < NCFG) begin
            checks++;
            failures++;
            $display("FAIL timeout: finished instances=%0d required=%0d", n_done, NCFG);
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
